dsqw_job_ctrl: RTL and testbench

DSQW_JOB_CTRL -- requirements
Module: dsqw_job_ctrl

---
 rtl/dsqw_pkg.sv | 32 +++
 rtl/dsqw_irq_regs.sv | 39 +++
 rtl/dsqw_job_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dsqw_job_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsqw_pkg.sv
// Shared definitions for the dsqw job controller: FSM encoding, phase IDs,
// status bit positions and the minimum legal image side.
// Pure declarations; no logic or timing of its own.
package dsqw_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // Datapath phases, in execution order
  localparam logic [1:0] PH_MOMENTS = 2'd0;
  localparam logic [1:0] PH_DIVIDE  = 2'd1;
  localparam logic [1:0] PH_REMAP   = 2'd2;

  // Status vector bit positions; external error sources start at STS_ERR_SRC
  localparam int STS_DONE        = 0;
  localparam int STS_ERR_SIZE    = 1;
  localparam int STS_ERR_TIMEOUT = 2;
  localparam int STS_ERR_SRC     = 3;

  // Smallest image side the datapath can process
  localparam int MIN_DIM = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dsqw_irq_regs.sv
// Sticky status bits with write-1-to-clear acknowledge and a masked interrupt.
// Latency: status updates one cycle after a set/ack; irq one cycle after status.
// No backpressure: set pulses are absorbed every cycle, set wins over ack.
module dsqw_irq_regs
  import dsqw_pkg::*;
#(
  parameter int N_ST = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_ST-1:0] set_i,
  input  logic [N_ST-1:0] ack_i,
  input  logic [N_ST-1:0] mask_i,
  output logic [N_ST-1:0] status_o,
  output logic            irq_o
);

  logic [N_ST-1:0] status_q;
  logic [N_ST-1:0] status_d;
  logic            irq_q;

  // A bit acknowledged in the same cycle it is set must stay set
  assign status_d = (status_q & ~ack_i) | set_i;

  // Sticky status and interrupt registers; irq follows status by one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |(status_q & mask_i);
    end
  end

  assign status_o = status_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/dsqw_job_ctrl.sv
// Job sequencer for the dsqw engine: checks job geometry, runs three datapath phases, collects errors into sticky status.
// Latency: start -> 1 check cycle -> first RUN cycle (sclr + phase_start); all outputs registered.
// No backpressure: start is dropped outside IDLE, phase_done ignored when not meaningful. Optional watchdog: DSQW_WDOG_EN.
module dsqw_job_ctrl
  import dsqw_pkg::*;
#(
  parameter int DIM_W   = 9,
  parameter int ADDR_W  = 17,
  parameter int MAX_DIM = 256,
  parameter int N_ERR   = 3,
  parameter int WDOG_W  = 16,
  localparam int N_ST   = 3 + N_ERR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              soft_rst_i,
  input  logic [DIM_W-1:0]  img_dim_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [ADDR_W-1:0] out_addr_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  input  logic [N_ERR-1:0]  err_src_i,
  input  logic              phase_done_i,
  input  logic [N_ST-1:0]   irq_mask_i,
  input  logic [N_ST-1:0]   irq_ack_i,
  output logic              idle_o,
  output logic              sclr_o,
  output logic              phase_start_o,
  output logic [1:0]        phase_id_o,
  output logic [N_ST-1:0]   status_o,
  output logic              irq_o
);

  // Area is dim*dim at full precision; address sums get one extra bit so the
  // comparison against 2^ADDR_W can never wrap.
  localparam int AW2 = 2 * DIM_W;
  localparam int SW  = max_int(ADDR_W, AW2) + 1;
  localparam logic [SW-1:0] ADDR_LIM = SW'(1) << ADDR_W;

  state_e            state_q;
  logic              idle_q;
  logic              sclr_q;
  logic              phase_start_q;
  logic [1:0]        phase_id_q;
  logic [DIM_W-1:0]  dim_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic [AW2-1:0]    area;
  logic [SW-1:0]     area_ext;
  logic [SW-1:0]     in_ext;
  logic [SW-1:0]     out_ext;
  logic [SW-1:0]     in_end;
  logic [SW-1:0]     out_end;
  logic              dim_bad;
  logic              range_bad;
  logic              overlap;
  logic              check_fail;

  logic              wdog_hit;
  logic              run_err;
  logic              pd_ok;
  logic [N_ST-1:0]   st_set;
  logic [N_ST-1:0]   mask_eff;

  // Geometry check on the parameters captured when the job was accepted
  assign area      = AW2'(dim_q) * AW2'(dim_q);
  assign area_ext  = SW'(area);
  assign in_ext    = SW'(in_addr_q);
  assign out_ext   = SW'(out_addr_q);
  assign in_end    = in_ext + area_ext;
  assign out_end   = out_ext + area_ext;
  assign dim_bad   = (dim_q < DIM_W'(MIN_DIM)) || (32'(dim_q) > 32'(MAX_DIM));
  assign range_bad = (in_end > ADDR_LIM) || (out_end > ADDR_LIM);
  assign overlap   = (in_ext < out_end) && (out_ext < in_end);
  assign check_fail = dim_bad || range_bad || overlap;

  // phase_done landing on a phase_start cycle belongs to the previous phase
  assign pd_ok   = phase_done_i && !phase_start_q;
  assign run_err = (|err_src_i) || wdog_hit;

`ifdef DSQW_WDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic [WDOG_W:0]   wdog_nxt;

  // wdog_q counts RUN cycles already spent in the current phase
  assign wdog_nxt = {1'b0, wdog_q} + 1'b1;
  assign wdog_hit = (state_q == ST_RUN) && (wdog_limit_i != '0) &&
                    (wdog_nxt == {1'b0, wdog_limit_i});
  assign mask_eff = irq_mask_i;

  // Per-phase watchdog: runs in RUN, restarts whenever a new phase begins
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst_i) begin
      wdog_q <= '0;
    end else if ((state_q == ST_RUN) && !pd_ok) begin
      wdog_q <= wdog_nxt[WDOG_W-1:0];
    end else begin
      wdog_q <= '0;
    end
  end
`else
  logic wdog_unused;

  assign wdog_unused = ^wdog_limit_i;
  assign wdog_hit    = 1'b0;
  assign mask_eff    = irq_mask_i & ~(N_ST'(1) << STS_ERR_TIMEOUT);
`endif

  // Status set pulses; an abort request leaves status untouched
  always_comb begin
    st_set = '0;
    if (!soft_rst_i) begin
      case (state_q)
        ST_CHECK: begin
          if (check_fail) st_set[STS_ERR_SIZE] = 1'b1;
        end
        ST_RUN: begin
          st_set[STS_ERR_SRC +: N_ERR] = err_src_i;
          if (wdog_hit) st_set[STS_ERR_TIMEOUT] = 1'b1;
          if (!run_err && pd_ok && (phase_id_q == PH_REMAP)) st_set[STS_DONE] = 1'b1;
        end
        default: st_set = '0;
      endcase
    end
  end

  // Job FSM with registered outputs; errors take priority over phase completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idle_q        <= 1'b1;
      sclr_q        <= 1'b0;
      phase_start_q <= 1'b0;
      phase_id_q    <= PH_MOMENTS;
      dim_q         <= '0;
      in_addr_q     <= '0;
      out_addr_q    <= '0;
    end else begin
      sclr_q        <= 1'b0;
      phase_start_q <= 1'b0;
      if (soft_rst_i) begin
        state_q    <= ST_IDLE;
        idle_q     <= 1'b1;
        phase_id_q <= PH_MOMENTS;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q    <= ST_CHECK;
              idle_q     <= 1'b0;
              dim_q      <= img_dim_i;
              in_addr_q  <= in_addr_i;
              out_addr_q <= out_addr_i;
            end
          end
          ST_CHECK: begin
            if (check_fail) begin
              state_q <= ST_IDLE;
              idle_q  <= 1'b1;
            end else begin
              state_q       <= ST_RUN;
              phase_id_q    <= PH_MOMENTS;
              sclr_q        <= 1'b1;
              phase_start_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (run_err) begin
              state_q <= ST_ABORT;
              sclr_q  <= 1'b1;
            end else if (pd_ok) begin
              if (phase_id_q == PH_REMAP) begin
                state_q <= ST_IDLE;
                idle_q  <= 1'b1;
              end else begin
                phase_id_q    <= phase_id_q + 2'd1;
                phase_start_q <= 1'b1;
              end
            end
          end
          ST_ABORT: begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  dsqw_irq_regs #(
    .N_ST(N_ST)
  ) u_irq_regs (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_i   (st_set),
    .ack_i   (irq_ack_i),
    .mask_i  (mask_eff),
    .status_o(status_o),
    .irq_o   (irq_o)
  );

  assign idle_o        = idle_q;
  assign sclr_o        = sclr_q;
  assign phase_start_o = phase_start_q;
  assign phase_id_o    = phase_id_q;

endmodule

// File: tb/tb_dsqw_job_ctrl.sv
// Directed bench for dsqw_job_ctrl: geometry checks, phase sequencing, errors,
// abort, sticky status/ack and the optional watchdog (DSQW_WDOG_EN).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_dsqw_job_ctrl;

  localparam int DIM_W  = 9;
  localparam int ADDR_W = 17;
  localparam int N_ERR  = 3;
  localparam int WDOG_W = 16;
  localparam int N_ST   = 3 + N_ERR;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              soft_rst;
  logic [DIM_W-1:0]  img_dim;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] out_addr;
  logic [WDOG_W-1:0] wdog_limit;
  logic [N_ERR-1:0]  err_src;
  logic              phase_done;
  logic [N_ST-1:0]   irq_mask;
  logic [N_ST-1:0]   irq_ack;
  logic              idle;
  logic              sclr;
  logic              phase_start;
  logic [1:0]        phase_id;
  logic [N_ST-1:0]   status;
  logic              irq;

  int total = 0;
  int bad   = 0;
  int ps_cnt = 0;
  int sclr_cnt = 0;
  int ps0;
  int sc0;

  always #5 clk = ~clk;

  dsqw_job_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .soft_rst_i   (soft_rst),
    .img_dim_i    (img_dim),
    .in_addr_i    (in_addr),
    .out_addr_i   (out_addr),
    .wdog_limit_i (wdog_limit),
    .err_src_i    (err_src),
    .phase_done_i (phase_done),
    .irq_mask_i   (irq_mask),
    .irq_ack_i    (irq_ack),
    .idle_o       (idle),
    .sclr_o       (sclr),
    .phase_start_o(phase_start),
    .phase_id_o   (phase_id),
    .status_o     (status),
    .irq_o        (irq)
  );

  // Pulse counters sampled on the falling edge
  always @(negedge clk) begin
    if (phase_start === 1'b1) ps_cnt++;
    if (sclr === 1'b1) sclr_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a job with legal geometry and stop in the first cycle of phase n
  task automatic run_to_phase(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      tick();
      phase_done = 1'b1;
      tick();
      phase_done = 1'b0;
    end
  endtask

  // One geometry check; passing jobs are aborted with soft_rst
  task automatic run_check(input string tag, input int dim, input int ia, input int oa, input bit pass);
    img_dim  = DIM_W'(dim);
    in_addr  = ADDR_W'(ia);
    out_addr = ADDR_W'(oa);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    if (pass) begin
      chk({tag, "_run"}, {31'd0, sclr}, 32'd1);
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      chk({tag, "_stat"}, 32'(status), 32'h0);
    end else begin
      chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
      chk({tag, "_stat"}, 32'(status), 32'h2);
      irq_ack = 6'h02;
      tick();
      irq_ack = '0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; soft_rst = 1'b0; img_dim = 9'd16;
    in_addr = '0; out_addr = 17'd256; wdog_limit = '0; err_src = '0;
    phase_done = 1'b1; irq_mask = '1; irq_ack = '0;
    tick();
    tick();
    // reset holds everything quiet even with start/phase_done asserted
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_sclr", {31'd0, sclr}, 32'd0);
    chk("rst_ps", {31'd0, phase_start}, 32'd0);
    chk("rst_pid", 32'(phase_id), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0; start = 1'b0; phase_done = 1'b0;
    irq_mask = 6'h01;
    tick();

    // Full job: 16x16 at 0 -> 256, phase_done after 10 cycles per phase
    ps0 = ps_cnt; sc0 = sclr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("j1_check_idle", {31'd0, idle}, 32'd0);
    tick();
    chk("j1_sclr", {31'd0, sclr}, 32'd1);
    chk("j1_ps0", {31'd0, phase_start}, 32'd1);
    chk("j1_pid0", 32'(phase_id), 32'd0);
    for (int p = 0; p < 3; p++) begin
      repeat (9) tick();
      chk("j1_pid_hold", 32'(phase_id), 32'(p));
      chk("j1_ps_low", {31'd0, phase_start}, 32'd0);
      phase_done = 1'b1;
      tick();
      phase_done = 1'b0;
      if (p < 2) begin
        chk("j1_ps_next", {31'd0, phase_start}, 32'd1);
        chk("j1_pid_next", 32'(phase_id), 32'(p + 1));
      end
    end
    chk("j1_idle", {31'd0, idle}, 32'd1);
    chk("j1_status", 32'(status), 32'h01);
    chk("j1_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("j1_irq", {31'd0, irq}, 32'd1);
    chk("j1_ps_count", 32'(ps_cnt - ps0), 32'd3);
    chk("j1_sclr_count", 32'(sclr_cnt - sc0), 32'd1);
    irq_ack = 6'h01;
    tick();
    irq_ack = '0;
    chk("j1_ack", 32'(status), 32'h0);
    tick();
    chk("j1_irq_clr", {31'd0, irq}, 32'd0);

    // Overlapping regions: 0..255 vs 200..455
    sc0 = sclr_cnt;
    out_addr = 17'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovl_check_idle", {31'd0, idle}, 32'd0);
    tick();
    chk("ovl_idle", {31'd0, idle}, 32'd1);
    chk("ovl_status", 32'(status), 32'h02);
    tick();
    chk("ovl_no_sclr", 32'(sclr_cnt - sc0), 32'd0);
    chk("ovl_irq_masked", {31'd0, irq}, 32'd0);
    irq_ack = 6'h02;
    tick();
    irq_ack = '0;

    // Dimension and address-range boundaries
    run_check("dim1", 1, 0, 256, 1'b0);
    run_check("dim257", 257, 0, 70000, 1'b0);
    run_check("dim2", 2, 0, 256, 1'b1);
    run_check("dim256", 256, 0, 65536, 1'b1);
    run_check("dim256_oob", 256, 0, 65537, 1'b0);
    run_check("dim256_ovl", 256, 0, 65535, 1'b0);

    // err_src ignored in IDLE/CHECK; phase_done ignored on phase_start
    img_dim = 9'd16; in_addr = '0; out_addr = 17'd256;
    err_src = 3'b111;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    err_src = '0;
    chk("err_idle_status", 32'(status), 32'h0);
    chk("err_idle_run", {31'd0, sclr}, 32'd1);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    chk("pd_on_ps_pid", 32'(phase_id), 32'd0);
    chk("pd_on_ps_ps", {31'd0, phase_start}, 32'd0);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    tick();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    chk("err_pid2", 32'(phase_id), 32'd2);
    tick();
    // error and final phase_done in the same cycle
    err_src = 3'b010;
    phase_done = 1'b1;
    tick();
    err_src = '0;
    phase_done = 1'b0;
    chk("err_abort_sclr", {31'd0, sclr}, 32'd1);
    chk("err_abort_idle", {31'd0, idle}, 32'd0);
    chk("err_status", 32'(status), 32'h10);
    tick();
    chk("err_back_idle", {31'd0, idle}, 32'd1);
    chk("err_sclr_end", {31'd0, sclr}, 32'd0);
    chk("err_sticky", 32'(status), 32'h10);
    irq_ack = 6'h10;
    tick();
    irq_ack = '0;

    // Watchdog with limit 5 and no phase_done
    wdog_limit = 16'd5;
    run_to_phase(0);
    repeat (4) tick();
    chk("wd_still_run", {31'd0, idle}, 32'd0);
    chk("wd_no_abort_yet", {31'd0, sclr}, 32'd0);
    tick();
`ifdef DSQW_WDOG_EN
    chk("wd_status", 32'(status), 32'h04);
    chk("wd_abort_sclr", {31'd0, sclr}, 32'd1);
    tick();
    chk("wd_idle", {31'd0, idle}, 32'd1);
    irq_ack = 6'h04;
    tick();
    irq_ack = '0;
`else
    chk("wd_off_status", 32'(status), 32'h0);
    chk("wd_off_sclr", {31'd0, sclr}, 32'd0);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
`endif
    wdog_limit = '0;
    run_to_phase(0);
    repeat (30) tick();
    chk("wd0_running", {31'd0, idle}, 32'd0);
    chk("wd0_status", 32'(status), 32'h0);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;

    // soft_rst in phase 1 with start asserted; status must survive
    run_check("pre_abort_fail", 1, 0, 256, 1'b0);
    img_dim = 9'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sr_pre_status", 32'(status), 32'h02);
    img_dim = 9'd16;
    run_to_phase(1);
    chk("sr_pid1", 32'(phase_id), 32'd1);
    tick();
    soft_rst = 1'b1;
    start = 1'b1;
    tick();
    soft_rst = 1'b0;
    start = 1'b0;
    chk("sr_idle", {31'd0, idle}, 32'd1);
    chk("sr_pid", 32'(phase_id), 32'd0);
    chk("sr_status", 32'(status), 32'h02);
    tick();
    chk("sr_stay_idle", {31'd0, idle}, 32'd1);
    soft_rst = 1'b1;
    start = 1'b1;
    tick();
    soft_rst = 1'b0;
    start = 1'b0;
    chk("sr_beats_start", {31'd0, idle}, 32'd1);

    // Ack coinciding with done-set: bit 0 stays, bit 1 clears
    run_to_phase(2);
    tick();
    phase_done = 1'b1;
    irq_ack = 6'h03;
    tick();
    phase_done = 1'b0;
    irq_ack = '0;
    chk("ack_set_status", 32'(status), 32'h01);
    chk("ack_set_idle", {31'd0, idle}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
